// File: rtl/mips_pkg.sv
// Shared MIPS-I encodings and instruction field positions for the pipeline stages.
// Constants and helpers only; no state, no latency, no flow control.
package mips_pkg;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_MSB  = 25;
    localparam int JADDR_LSB  = 0;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register with next-PC select (jump > branch > PC+4); one-cycle update.
// en low holds the PC regardless of redirect requests; reset overrides everything.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        jump,
    input  logic        branch,
    input  logic [31:0] jump_target,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    // Wraps silently from 32'hFFFF_FFFC to 0.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = jump_target;
        end else if (branch) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (en) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID register; PCF to InstrD in one cycle, decode fields combinational from InstrD.
// StallF/StallD hold their registers, FlushD inserts a NOP and wins over StallD.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic [WIDTH-1:0] PCBranchD,
    input  logic [WIDTH-1:0] ImemRdata,
    output logic [WIDTH-1:0] ImemAddr,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD,
    output logic [5:0]       OpcodeD,
    output logic [5:0]       FunctD,
    output logic [4:0]       RsD,
    output logic [4:0]       RtD,
    output logic [4:0]       RdD,
    output logic [WIDTH-1:0] SignImmD
);

    logic [31:0] pc_plus4_f;
    logic [31:0] jump_target_d;

    assign jump_target_d = {PCPlus4D[31:28], InstrD[JADDR_MSB:JADDR_LSB], 2'b00};

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .en            (~StallF),
        .jump          (JumpD),
        .branch        (PCSrcD),
        .jump_target   (jump_target_d),
        .branch_target (PCBranchD),
        .pc            (PCF),
        .pc_plus4      (pc_plus4_f)
    );

    // Straight from the register so the imem address has no input-to-output path.
    assign ImemAddr = PCF;

    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= INSTR_NOP;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= INSTR_NOP;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= ImemRdata;
            PCPlus4D <= pc_plus4_f;
            ValidD   <= 1'b1;
        end
    end

    assign OpcodeD  = InstrD[OPCODE_MSB:OPCODE_LSB];
    assign FunctD   = InstrD[FUNCT_MSB:FUNCT_LSB];
    assign RsD      = InstrD[RS_MSB:RS_LSB];
    assign RtD      = InstrD[RT_MSB:RT_LSB];
    assign RdD      = InstrD[RD_MSB:RD_LSB];
    assign SignImmD = sign_ext16(InstrD[IMM_MSB:IMM_LSB]);

endmodule
